// File: rtl/pll_seq_pkg.sv
// Shared state encoding, sizing helper and constants for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  localparam int unsigned LOSS_CNT_W = 8;
  localparam int unsigned RETRY_W    = 4;

  // Width of the shared phase counter: wide enough for the largest terminal count.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    int unsigned w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = $clog2(m);
    return w + 1;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Single-bit two-stage synchronizer, cleared to 0 by the async reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Capture the asynchronous level through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for and qualifies lock,
// then releases the downstream system reset; re-runs on lock loss with a
// bounded number of retries before parking in FAULT.
// Optional lock-loss counter output enabled by defining PLL_SEQ_LOSS_CNT_EN.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES     = 27,
  parameter int unsigned LOCK_STABLE_CYCLES = 2700,
  parameter int unsigned LOCK_TIMEOUT       = 27000,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic               soft_reset_req,
  output logic               pll_rst,
  output logic               sys_rst_n,
  output logic               ready,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_cnt
`ifdef PLL_SEQ_LOSS_CNT_EN
  ,
  output logic [LOSS_CNT_W-1:0] loss_cnt
`endif
);

  localparam int unsigned CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT);

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               lock_s;
  logic [RETRY_W-1:0] retry_inc_c;

  assign retry_inc_c = retry_cnt + RETRY_W'(1);

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // Sequencer: one shared counter per phase, every output registered.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RESET_PLL;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      fault     <= 1'b0;
      retry_cnt <= '0;
    end else if (soft_reset_req) begin
      // A soft request restarts the whole sequence from any state.
      state     <= RESET_PLL;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      fault     <= 1'b0;
      retry_cnt <= '0;
    end else begin
      case (state)
        RESET_PLL: begin
          if (cnt == RST_LAST) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        WAIT_LOCK: begin
          if (lock_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            // Attempt failed: charge a retry, then retry or give up.
            retry_cnt <= retry_inc_c;
            cnt       <= '0;
            if (retry_inc_c == RETRY_LIMIT) begin
              state <= FAULT;
              fault <= 1'b1;
            end else begin
              state   <= RESET_PLL;
              pll_rst <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        STABLE: begin
          if (!lock_s) begin
            // Chatter is not a failed attempt; reopen the lock window.
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state     <= RUN;
            cnt       <= '0;
            sys_rst_n <= 1'b1;
            ready     <= 1'b1;
            retry_cnt <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RUN: begin
          if (!lock_s) begin
            state     <= RESET_PLL;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
          end
        end

        FAULT: begin
          pll_rst   <= 1'b0;
          sys_rst_n <= 1'b0;
          ready     <= 1'b0;
          fault     <= 1'b1;
        end

        default: begin
          state     <= RESET_PLL;
          cnt       <= '0;
          pll_rst   <= 1'b1;
          sys_rst_n <= 1'b0;
          ready     <= 1'b0;
          fault     <= 1'b0;
        end
      endcase
    end
  end

`ifdef PLL_SEQ_LOSS_CNT_EN
  logic run_lock_lost_c;

  // A soft request taking the sequencer out of RUN is not a lock loss.
  assign run_lock_lost_c = (state == RUN) && !lock_s && !soft_reset_req;

  // Saturating lock-loss counter; only the hard reset clears it.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt <= '0;
    end else if (run_lock_lost_c && (loss_cnt != '1)) begin
      loss_cnt <= loss_cnt + LOSS_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: per-cycle expected outputs come
// from a window/segment model of the bring-up rules over the lock waveform.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

  localparam int P    = 4;   // pll_rst pulse length
  localparam int S    = 8;   // stable qualification length
  localparam int T    = 32;  // lock window length
  localparam int MAXR = 2;   // failed attempts before fault
  localparam int NMAX = 256;

  typedef struct {
    bit pr;
    bit sy;
    bit fa;
    int rc;
    int lc;
    int cyc;
  } exp_t;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       soft_reset_req;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  bit   lk [NMAX];
  bit   sf [NMAX];
  exp_t expv [NMAX];
  int   n_cyc;
  exp_t exp_q [$];
  int   n_cmp;
  int   n_bad;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES     (P),
    .LOCK_STABLE_CYCLES (S),
    .LOCK_TIMEOUT       (T),
    .MAX_RETRIES        (MAXR)
  ) dut (
    .refclk         (refclk),
    .rst_n          (rst_n),
    .pll_locked     (pll_locked),
    .soft_reset_req (soft_reset_req),
    .pll_rst        (pll_rst),
    .sys_rst_n      (sys_rst_n),
    .ready          (ready),
    .fault          (fault),
    .retry_cnt      (retry_cnt)
`ifdef PLL_SEQ_LOSS_CNT_EN
    ,
    .loss_cnt       (loss_cnt)
`endif
  );

`ifndef PLL_SEQ_LOSS_CNT_EN
  assign loss_cnt = 8'd0;
`endif

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic check(input string nm, input int cyc, input logic [7:0] act, input logic [7:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, want);
    end
  endtask

  // Synchronized lock as seen by the sequencer in cycle j.
  function automatic bit lock_at(input int j);
    if (j < 2 || j - 2 >= n_cyc) return 1'b0;
    return lk[j-2];
  endfunction

  function automatic int first_soft(input int a, input int b);
    for (int j = a; j <= b && j < n_cyc; j++) if (sf[j]) return j;
    return -1;
  endfunction

  function automatic int first_lock(input int a, input int b, input bit v);
    for (int j = a; j <= b && j < n_cyc; j++) if (lock_at(j) == v) return j;
    return -1;
  endfunction

  task automatic fill(input int a, input int b, input bit pr, input bit sy,
                      input bit fa, input int rc, input int lc);
    for (int j = a; j <= b && j < n_cyc; j++) begin
      expv[j].pr  = pr;
      expv[j].sy  = sy;
      expv[j].fa  = fa;
      expv[j].rc  = rc;
      expv[j].lc  = lc;
      expv[j].cyc = j;
    end
  endtask

  // Walk the lock waveform attempt by attempt, window by window.
  task automatic build_model();
    int  t, r, lc, w, f, k, e, q, u, s;
    bit  done;
    t = 0; r = 0; lc = 0;
    while (t < n_cyc) begin
      q = first_soft(t, t + P - 1);
      if (q >= 0) begin
        fill(t, q, 1, 0, 0, r, lc);
        t = q + 1; r = 0;
        continue;
      end
      fill(t, t + P - 1, 1, 0, 0, r, lc);
      w = t + P;
      t = n_cyc;
      done = 1'b0;
      while (!done && w < n_cyc) begin
        k = -1;
        f = first_lock(w, w + T - 1, 1'b1);
        if (f < 0) e = w + T - 1;
        else begin
          k = first_lock(f + 1, f + S, 1'b0);
          e = (k < 0) ? f + S : k;
        end
        q = first_soft(w, e);
        if (q >= 0) begin
          fill(w, q, 0, 0, 0, r, lc);
          t = q + 1; r = 0; done = 1'b1;
        end else begin
          fill(w, e, 0, 0, 0, r, lc);
          if (f < 0) begin
            r++;
            if (r == MAXR) begin
              q = first_soft(e + 1, n_cyc - 1);
              fill(e + 1, (q < 0) ? n_cyc - 1 : q, 0, 0, 1, r, lc);
              if (q < 0) t = n_cyc;
              else begin t = q + 1; r = 0; end
            end else begin
              t = e + 1;
            end
            done = 1'b1;
          end else if (k >= 0) begin
            w = k + 1;
          end else begin
            s = f + S + 1;
            r = 0;
            u = first_lock(s, n_cyc - 1, 1'b0);
            q = first_soft(s, (u < 0) ? n_cyc - 1 : u);
            fill(s, (q >= 0) ? q : ((u < 0) ? n_cyc - 1 : u), 0, 1, 0, 0, lc);
            if (q >= 0) t = q + 1;
            else if (u >= 0) begin
              lc = (lc < 255) ? lc + 1 : 255;
              t = u + 1;
            end else t = n_cyc;
            done = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic clear_stim(input int n);
    for (int i = 0; i < NMAX; i++) begin lk[i] = 1'b0; sf[i] = 1'b0; end
    n_cyc = n;
  endtask

  task automatic gen_random(input int n);
    int prof, k, len;
    bit lvl;
    clear_stim(n);
    prof = int'($urandom_range(0, 3));
    k = 0;
    lvl = 1'b0;
    while (k < n) begin
      case (prof)
        0:       len = lvl ? int'($urandom_range(20, 80)) : int'($urandom_range(1, 20));
        1:       len = int'($urandom_range(1, 12));
        2:       len = lvl ? int'($urandom_range(1, 10)) : int'($urandom_range(20, 60));
        default: len = int'($urandom_range(5, 60));
      endcase
      for (int i = 0; i < len && k < n; i++) begin lk[k] = lvl; k++; end
      lvl = !lvl;
    end
    for (int i = 0; i < n; i++) sf[i] = ($urandom_range(0, 79) == 0);
  endtask

  // Hard reset, then drive n cycles, pushing each cycle's expectation as it is issued.
  task automatic run_episode(input int n, input int abort_at);
    exp_t e;
    n_cyc = n;
    build_model();
    @(posedge refclk); #2;
    rst_n = 1'b0; pll_locked = 1'b0; soft_reset_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge refclk);
      e.pr = 1'b1; e.sy = 1'b0; e.fa = 1'b0; e.rc = 0; e.lc = 0; e.cyc = -1;
      exp_q.push_back(e);
    end
    for (int k = 0; k < n; k++) begin
      @(negedge refclk);
      exp_q.push_back(expv[k]);
      rst_n = 1'b1;
      pll_locked = lk[k];
      soft_reset_req = sf[k];
      if (k == abort_at) begin
        @(posedge refclk); #2;
        rst_n = 1'b0;
        #1;
        check("async_pll_rst", k + 1, 8'(pll_rst), 8'd1);
        check("async_sys_rst_n", k + 1, 8'(sys_rst_n), 8'd0);
        check("async_ready", k + 1, 8'(ready), 8'd0);
        break;
      end
    end
  endtask

  // Monitor: pop one expectation per cycle and compare every output.
  initial begin
    exp_t e;
    forever begin
      @(negedge refclk); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pll_rst", e.cyc, 8'(pll_rst), 8'(e.pr));
        check("sys_rst_n", e.cyc, 8'(sys_rst_n), 8'(e.sy));
        check("ready", e.cyc, 8'(ready), 8'(e.sy));
        check("fault", e.cyc, 8'(fault), 8'(e.fa));
        check("retry_cnt", e.cyc, 8'(retry_cnt), 8'(e.rc));
`ifdef PLL_SEQ_LOSS_CNT_EN
        check("loss_cnt", e.cyc, loss_cnt, 8'(e.lc));
`endif
      end
    end
  end

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; pll_locked = 1'b0; soft_reset_req = 1'b0;
    repeat (2) @(negedge refclk);

    // Clean bring-up: lock 10 cycles after pll_rst falls.
    clear_stim(50);
    for (int k = 0; k < 50; k++) lk[k] = (k >= 14);
    run_episode(50, -1);

    // One-cycle lock drop at stable count 5.
    clear_stim(60);
    for (int k = 0; k < 60; k++) lk[k] = (k >= 14) && (k != 20);
    run_episode(60, -1);

    // No lock at all: two timeouts, then fault.
    clear_stim(90);
    run_episode(90, -1);

    // Lock loss while running, then recovery.
    clear_stim(80);
    for (int k = 0; k < 80; k++) lk[k] = (k >= 14) && !(k >= 40 && k < 46);
    run_episode(80, -1);

    // Soft request out of FAULT.
    clear_stim(110);
    for (int k = 0; k < 110; k++) lk[k] = (k >= 90);
    sf[80] = 1'b1;
    run_episode(110, -1);

    // Soft request coinciding with lock loss in RUN.
    clear_stim(70);
    for (int k = 0; k < 70; k++) lk[k] = (k >= 14) && (k < 40);
    sf[42] = 1'b1;
    run_episode(70, -1);

    // Hard reset mid-STABLE, then a full clean sequence.
    clear_stim(30);
    for (int k = 0; k < 30; k++) lk[k] = (k >= 14);
    run_episode(30, 20);
    clear_stim(50);
    for (int k = 0; k < 50; k++) lk[k] = (k >= 14);
    run_episode(50, -1);

    // Randomized lock waveforms with sparse soft requests.
    for (int ep = 0; ep < 14; ep++) begin
      gen_random(160);
      run_episode(160, -1);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge refclk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
